// File: rtl/rl_lj_pair_scheduler_if.sv
// Position-RAM read port and force-pipeline issue/return handshake shared by the
// pair scheduler (master) and the RAM / force pipeline side (slave).
interface rl_lj_pair_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 12
);
  logic                         mem_rd_en;
  logic [ID_WIDTH-1:0]          mem_rd_addr;
  logic signed [DATA_WIDTH-1:0] mem_rd_x;
  logic signed [DATA_WIDTH-1:0] mem_rd_y;
  logic signed [DATA_WIDTH-1:0] mem_rd_z;

  logic                         pipe_iready;
  logic                         pipe_ivalid;
  logic signed [DATA_WIDTH-1:0] pipe_ref_x;
  logic signed [DATA_WIDTH-1:0] pipe_ref_y;
  logic signed [DATA_WIDTH-1:0] pipe_ref_z;
  logic signed [DATA_WIDTH-1:0] pipe_nb_x;
  logic signed [DATA_WIDTH-1:0] pipe_nb_y;
  logic signed [DATA_WIDTH-1:0] pipe_nb_z;
  logic [ID_WIDTH-1:0]          pipe_ref_id;
  logic [ID_WIDTH-1:0]          pipe_nb_id;
  logic                         pipe_ovalid;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_x, mem_rd_y, mem_rd_z,
    input  pipe_iready, pipe_ovalid,
    output pipe_ivalid, pipe_ref_x, pipe_ref_y, pipe_ref_z,
    output pipe_nb_x, pipe_nb_y, pipe_nb_z, pipe_ref_id, pipe_nb_id
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_x, mem_rd_y, mem_rd_z,
    output pipe_iready, pipe_ovalid,
    input  pipe_ivalid, pipe_ref_x, pipe_ref_y, pipe_ref_z,
    input  pipe_nb_x, pipe_nb_y, pipe_nb_z, pipe_ref_id, pipe_nb_id
  );
endinterface

// File: rtl/rl_lj_pair_scheduler.sv
// Walks the half-shell pair list (i < j < N) of one particle set and feeds the
// RL LJ force pipeline, bounding in-flight pairs with a credit counter.
module rl_lj_pair_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 12,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CREDIT_WIDTH    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ID_WIDTH-1:0]    particle_num,
  output logic                   busy,
  output logic                   done,
  output logic                   err_underflow,
  output logic [2*ID_WIDTH-1:0]  pair_count,
  rl_lj_pair_scheduler_if.master bus
);

  localparam int CW1 = CREDIT_WIDTH + 1;
  localparam logic [CREDIT_WIDTH:0] CREDIT_LIMIT = CW1'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE, LOAD_REF, LATCH_REF, STREAM, NEXT_REF, DRAIN, DONE
  } state_t;

  state_t                       state;
  logic [ID_WIDTH-1:0]          n_num;
  logic [ID_WIDTH-1:0]          i_idx;
  logic [ID_WIDTH-1:0]          j_idx;
  logic [CREDIT_WIDTH-1:0]      outstanding;
  logic signed [DATA_WIDTH-1:0] ref_x, ref_y, ref_z;

  logic                         vld_p0;
  logic [ID_WIDTH-1:0]          ref_id_p0;
  logic [ID_WIDTH-1:0]          nb_id_p0;

  logic [CREDIT_WIDTH:0]        credit_used;
  logic                         issue;
  logic                         ov_underflow;
  logic                         ret_ok;

  // A read issued last cycle becomes a pair this cycle but is not yet counted
  // in outstanding, so it must be charged against the credit limit here.
  assign credit_used  = {1'b0, outstanding} + {{CREDIT_WIDTH{1'b0}}, vld_p0};
  assign issue        = (state == STREAM) && bus.pipe_iready && (credit_used < CREDIT_LIMIT);
  assign ov_underflow = bus.pipe_ovalid && (outstanding == '0);
  assign ret_ok       = bus.pipe_ovalid && (outstanding != '0);

  always_comb begin
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    if (state == LOAD_REF) begin
      bus.mem_rd_en   = 1'b1;
      bus.mem_rd_addr = i_idx;
    end else if (issue) begin
      bus.mem_rd_en   = 1'b1;
      bus.mem_rd_addr = j_idx;
    end
  end

  // ---- p0: RAM data arrives, pair presented to the force pipeline ----
  assign bus.pipe_ivalid = vld_p0;
  assign bus.pipe_nb_x   = vld_p0 ? bus.mem_rd_x : '0;
  assign bus.pipe_nb_y   = vld_p0 ? bus.mem_rd_y : '0;
  assign bus.pipe_nb_z   = vld_p0 ? bus.mem_rd_z : '0;
  assign bus.pipe_ref_x  = ref_x;
  assign bus.pipe_ref_y  = ref_y;
  assign bus.pipe_ref_z  = ref_z;
  assign bus.pipe_ref_id = ref_id_p0;
  assign bus.pipe_nb_id  = nb_id_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n_num         <= '0;
      i_idx         <= '0;
      j_idx         <= '0;
      outstanding   <= '0;
      pair_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_underflow <= 1'b0;
      vld_p0        <= 1'b0;
      ref_id_p0     <= '0;
      nb_id_p0      <= '0;
      ref_x         <= '0;
      ref_y         <= '0;
      ref_z         <= '0;
    end else begin
      vld_p0 <= issue;
      if (issue) begin
        ref_id_p0 <= i_idx;
        nb_id_p0  <= j_idx;
      end

      case ({vld_p0, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (vld_p0) pair_count <= pair_count + 1'b1;
      done <= 1'b0;

      if (state == IDLE && start) err_underflow <= 1'b0;
      else if (ov_underflow)      err_underflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            n_num      <= particle_num;
            i_idx      <= '0;
            pair_count <= '0;
            busy       <= 1'b1;
            state      <= (particle_num < 2) ? DRAIN : LOAD_REF;
          end
        end
        LOAD_REF:  state <= LATCH_REF;
        LATCH_REF: begin
          ref_x <= bus.mem_rd_x;
          ref_y <= bus.mem_rd_y;
          ref_z <= bus.mem_rd_z;
          j_idx <= i_idx + 1'b1;
          state <= STREAM;
        end
        STREAM: begin
          if (issue) begin
            j_idx <= j_idx + 1'b1;
            if (j_idx == n_num - 1'b1) state <= NEXT_REF;
          end
        end
        NEXT_REF: begin
          if ((i_idx + 1'b1) >= (n_num - 1'b1)) begin
            state <= DRAIN;
          end else begin
            i_idx <= i_idx + 1'b1;
            state <= LOAD_REF;
          end
        end
        DRAIN: begin
          if (outstanding == '0 && !vld_p0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_lj_pair_scheduler.sv
// Bench for rl_lj_pair_scheduler: random position RAM, echoing force-pipeline
// model and a row-major pair-list reference.
module tb_rl_lj_pair_scheduler;
  localparam int DW = 32;
  localparam int IW = 12;
  localparam int MO = 32;
  localparam int CW = 6;
  localparam int LAT = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [IW-1:0] particle_num = '0;
  logic busy, done, err_underflow;
  logic [2*IW-1:0] pair_count;

  rl_lj_pair_scheduler_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  rl_lj_pair_scheduler #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO), .CREDIT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .particle_num(particle_num),
    .busy(busy), .done(done), .err_underflow(err_underflow),
    .pair_count(pair_count), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic signed [DW-1:0] mem_x [64];
  logic signed [DW-1:0] mem_y [64];
  logic signed [DW-1:0] mem_z [64];

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_x <= mem_x[bus.mem_rd_addr[5:0]];
      bus.mem_rd_y <= mem_y[bus.mem_rd_addr[5:0]];
      bus.mem_rd_z <= mem_z[bus.mem_rd_addr[5:0]];
    end
  end

  typedef struct {
    int c; int ri; int ni;
    logic signed [DW-1:0] rx, ry, rz, nx, ny, nz;
  } obs_t;
  typedef struct { int i; int j; } pair_t;

  obs_t  obs_q[$];
  pair_t exp_q[$];
  int    rel_q[$];

  int iv_total = 0, ov_total = 0, peak = 0, peak_seen = 0;
  int done_cnt = 0, done_cyc = 0, ov_last = 0, rd_cnt = 0;
  logic busy_at_done = 1'b0;
  int hold_until = 0;
  int peak_epoch = 0;
  bit force_ov = 1'b0;

  // Monitor plus force-pipeline model: each pair returns LAT cycles later, or
  // at hold_until if that is later; at most one return per cycle.
  always @(negedge clk) begin
    obs_t o;
    bit ov;
    if (peak_epoch != peak_seen) begin
      peak_seen = peak_epoch;
      peak = 0;
    end
    if (bus.mem_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (bus.pipe_ivalid) begin
      o.c = cyc; o.ri = int'(bus.pipe_ref_id); o.ni = int'(bus.pipe_nb_id);
      o.rx = bus.pipe_ref_x; o.ry = bus.pipe_ref_y; o.rz = bus.pipe_ref_z;
      o.nx = bus.pipe_nb_x;  o.ny = bus.pipe_nb_y;  o.nz = bus.pipe_nb_z;
      obs_q.push_back(o);
      iv_total++;
      rel_q.push_back((cyc + LAT > hold_until) ? cyc + LAT : hold_until);
    end
    ov = force_ov;
    if (rel_q.size() > 0 && rel_q[0] <= cyc) begin
      void'(rel_q.pop_front());
      ov = 1'b1;
      ov_total++;
      ov_last = cyc;
    end
    bus.pipe_ovalid = ov;
    if (iv_total - ov_total > peak) peak = iv_total - ov_total;
  end

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++) begin
        pair_t p;
        p.i = i; p.j = j;
        exp_q.push_back(p);
      end
  endtask

  task automatic do_start(input int n, output int s);
    @(posedge clk); #2;
    start = 1'b1;
    particle_num = n[IW-1:0];
    s = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd, output bit to);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #2;
      if (rnd) bus.pipe_iready = 1'($urandom_range(0, 1));
      k++;
    end
    to = (done_cnt == d0);
    bus.pipe_iready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({busy, done, err_underflow} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl busy/done/err=%b want 000", {busy, done, err_underflow});
    end
    total++;
    if (pair_count !== '0) begin
      bad++; $display("FAIL reset_pair_count got %0d want 0", pair_count);
    end
    total++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== '0 || bus.pipe_ivalid !== 1'b0) begin
      bad++; $display("FAIL reset_strobes rd_en=%b addr=%0d ivalid=%b want 0", bus.mem_rd_en, bus.mem_rd_addr, bus.pipe_ivalid);
    end
    total++;
    if (bus.pipe_ref_id !== '0 || bus.pipe_nb_id !== '0 || bus.pipe_ref_x !== '0 || bus.pipe_ref_y !== '0 ||
        bus.pipe_ref_z !== '0 || bus.pipe_nb_x !== '0 || bus.pipe_nb_y !== '0 || bus.pipe_nb_z !== '0) begin
      bad++; $display("FAIL reset_pipe_data ref_id=%0d nb_id=%0d ref_x=%h nb_x=%h want 0", bus.pipe_ref_id, bus.pipe_nb_id, bus.pipe_ref_x, bus.pipe_nb_x);
    end
    rst = 1'b0;
  endtask

  task automatic test_n3();
    int s, d0, base;
    int exp_c[3];
    bit to;
    exp_c[0] = 4; exp_c[1] = 5; exp_c[2] = 9;
    d0 = done_cnt; base = obs_q.size();
    do_start(3, s);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL n3_busy got %b want 1", busy); end
    wait_done(d0, 500, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL n3_timeout got no done want done"); end
    build_exp(3);
    total++;
    if (obs_q.size() - base !== 3) begin bad++; $display("FAIL n3_count got %0d want 3", obs_q.size() - base); end
    for (int k = 0; k < 3 && base + k < obs_q.size(); k++) begin
      obs_t o;
      o = obs_q[base + k];
      total++;
      if (o.c - s !== exp_c[k] || o.ri !== exp_q[k].i || o.ni !== exp_q[k].j ||
          o.rx !== mem_x[exp_q[k].i] || o.ry !== mem_y[exp_q[k].i] || o.rz !== mem_z[exp_q[k].i] ||
          o.nx !== mem_x[exp_q[k].j] || o.ny !== mem_y[exp_q[k].j] || o.nz !== mem_z[exp_q[k].j]) begin
        bad++;
        $display("FAIL n3_pair[%0d] got cyc+%0d (%0d,%0d) rx=%h nx=%h want cyc+%0d (%0d,%0d) rx=%h nx=%h",
                 k, o.c - s, o.ri, o.ni, o.rx, o.nx, exp_c[k], exp_q[k].i, exp_q[k].j, mem_x[exp_q[k].i], mem_x[exp_q[k].j]);
      end
    end
    total++;
    if (pair_count !== 3) begin bad++; $display("FAIL n3_pair_count got %0d want 3", pair_count); end
    total++;
    if (!(done_cyc > ov_last && done_cyc <= ov_last + 3) || busy_at_done !== 1'b0) begin
      bad++; $display("FAIL n3_done got done@%0d busy=%b want after last return @%0d with busy=0", done_cyc, busy_at_done, ov_last);
    end
  endtask

  task automatic test_small_n();
    int s, d0, base, rd0;
    bit to;
    for (int n = 0; n < 2; n++) begin
      d0 = done_cnt; base = obs_q.size(); rd0 = rd_cnt;
      do_start(n, s);
      wait_done(d0, 50, 1'b0, to);
      total++;
      if (to || done_cyc !== s + 2) begin
        bad++; $display("FAIL small_done n=%0d got done@+%0d timeout=%b want +2", n, done_cyc - s, to);
      end
      total++;
      if (rd_cnt !== rd0 || obs_q.size() !== base) begin
        bad++; $display("FAIL small_activity n=%0d got reads=%0d pairs=%0d want 0 0", n, rd_cnt - rd0, obs_q.size() - base);
      end
      total++;
      if (pair_count !== '0) begin bad++; $display("FAIL small_pair_count n=%0d got %0d want 0", n, pair_count); end
    end
  endtask

  task automatic test_random_ready();
    int s, d0, base;
    bit to;
    d0 = done_cnt; base = obs_q.size();
    do_start(20, s);
    wait_done(d0, 6000, 1'b1, to);
    total++;
    if (to) begin bad++; $display("FAIL rnd_timeout got no done want done"); end
    build_exp(20);
    total++;
    if (obs_q.size() - base !== exp_q.size() || pair_count !== 190) begin
      bad++; $display("FAIL rnd_count got pairs=%0d pair_count=%0d want 190", obs_q.size() - base, pair_count);
    end
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      obs_t o;
      o = obs_q[base + k];
      total++;
      if (o.ri !== exp_q[k].i || o.ni !== exp_q[k].j ||
          o.rx !== mem_x[exp_q[k].i] || o.ry !== mem_y[exp_q[k].i] || o.rz !== mem_z[exp_q[k].i] ||
          o.nx !== mem_x[exp_q[k].j] || o.ny !== mem_y[exp_q[k].j] || o.nz !== mem_z[exp_q[k].j]) begin
        bad++;
        $display("FAIL rnd_pair[%0d] got (%0d,%0d) rx=%h nx=%h want (%0d,%0d) rx=%h nx=%h",
                 k, o.ri, o.ni, o.rx, o.nx, exp_q[k].i, exp_q[k].j, mem_x[exp_q[k].i], mem_x[exp_q[k].j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int s, d0, base;
    bit to;
    peak_epoch++;
    d0 = done_cnt; base = obs_q.size();
    hold_until = cyc + 200;
    do_start(64, s);
    repeat (149) @(posedge clk);
    #2;
    total++;
    if (obs_q.size() - base !== MO || peak !== MO) begin
      bad++; $display("FAIL bp_stall got issued=%0d in_flight=%0d want %0d", obs_q.size() - base, peak, MO);
    end
    wait_done(d0, 20000, 1'b0, to);
    hold_until = 0;
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got no done want done"); end
    total++;
    if (pair_count !== 2016 || peak > MO) begin
      bad++; $display("FAIL bp_total got pair_count=%0d peak=%0d want 2016 peak<=%0d", pair_count, peak, MO);
    end
    build_exp(64);
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      obs_t o;
      o = obs_q[base + k];
      total++;
      if (o.ri !== exp_q[k].i || o.ni !== exp_q[k].j ||
          o.rx !== mem_x[exp_q[k].i] || o.ry !== mem_y[exp_q[k].i] || o.rz !== mem_z[exp_q[k].i] ||
          o.nx !== mem_x[exp_q[k].j] || o.ny !== mem_y[exp_q[k].j] || o.nz !== mem_z[exp_q[k].j]) begin
        bad++;
        $display("FAIL bp_pair[%0d] got (%0d,%0d) rx=%h nx=%h want (%0d,%0d) rx=%h nx=%h",
                 k, o.ri, o.ni, o.rx, o.nx, exp_q[k].i, exp_q[k].j, mem_x[exp_q[k].i], mem_x[exp_q[k].j]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int s, d0, base, k;
    bit to;
    base = obs_q.size();
    do_start(50, s);
    k = 0;
    while (obs_q.size() - base < 100 && k < 3000) begin
      @(posedge clk); #2;
      k++;
    end
    total++;
    if (obs_q.size() - base < 100) begin bad++; $display("FAIL midrst_progress got %0d pairs want >=100", obs_q.size() - base); end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    total++;
    if ({busy, done, err_underflow} !== 3'b000 || pair_count !== '0) begin
      bad++; $display("FAIL midrst_ctrl busy/done/err=%b pair_count=%0d want 000 0", {busy, done, err_underflow}, pair_count);
    end
    total++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_rd_addr !== '0 || bus.pipe_ivalid !== 1'b0 ||
        bus.pipe_ref_id !== '0 || bus.pipe_nb_id !== '0 || bus.pipe_ref_x !== '0 || bus.pipe_nb_x !== '0) begin
      bad++; $display("FAIL midrst_bus rd_en=%b addr=%0d ivalid=%b ref_id=%0d nb_id=%0d ref_x=%h want 0",
                      bus.mem_rd_en, bus.mem_rd_addr, bus.pipe_ivalid, bus.pipe_ref_id, bus.pipe_nb_id, bus.pipe_ref_x);
    end
    repeat (40) @(posedge clk);
    #2;
    total++;
    if (err_underflow !== 1'b1) begin bad++; $display("FAIL midrst_underflow got %b want 1", err_underflow); end
    d0 = done_cnt; base = obs_q.size();
    do_start(50, s);
    total++;
    if (err_underflow !== 1'b0) begin bad++; $display("FAIL midrst_err_clear got %b want 0", err_underflow); end
    wait_done(d0, 20000, 1'b0, to);
    total++;
    if (to || pair_count !== 1225) begin
      bad++; $display("FAIL midrst_fresh got pair_count=%0d timeout=%b want 1225", pair_count, to);
    end
    build_exp(50);
    for (int m = 0; m < exp_q.size() && base + m < obs_q.size(); m++) begin
      obs_t o;
      o = obs_q[base + m];
      total++;
      if (o.ri !== exp_q[m].i || o.ni !== exp_q[m].j ||
          o.rx !== mem_x[exp_q[m].i] || o.ry !== mem_y[exp_q[m].i] || o.rz !== mem_z[exp_q[m].i] ||
          o.nx !== mem_x[exp_q[m].j] || o.ny !== mem_y[exp_q[m].j] || o.nz !== mem_z[exp_q[m].j]) begin
        bad++;
        $display("FAIL midrst_pair[%0d] got (%0d,%0d) rx=%h nx=%h want (%0d,%0d) rx=%h nx=%h",
                 m, o.ri, o.ni, o.rx, o.nx, exp_q[m].i, exp_q[m].j, mem_x[exp_q[m].i], mem_x[exp_q[m].j]);
      end
    end
  endtask

  task automatic test_spurious_ovalid();
    int s, d0;
    bit to;
    @(posedge clk); #2;
    total++;
    if (err_underflow !== 1'b0) begin bad++; $display("FAIL spur_pre got %b want 0", err_underflow); end
    force_ov = 1'b1;
    @(posedge clk); #2;
    force_ov = 1'b0;
    total++;
    if (err_underflow !== 1'b1) begin bad++; $display("FAIL spur_set got %b want 1", err_underflow); end
    repeat (5) @(posedge clk);
    #2;
    total++;
    if (err_underflow !== 1'b1) begin bad++; $display("FAIL spur_sticky got %b want 1", err_underflow); end
    d0 = done_cnt;
    do_start(2, s);
    total++;
    if (err_underflow !== 1'b0) begin bad++; $display("FAIL spur_clear got %b want 0", err_underflow); end
    wait_done(d0, 300, 1'b0, to);
    total++;
    if (to || pair_count !== 1 || !(done_cyc > ov_last && done_cyc <= ov_last + 3)) begin
      bad++; $display("FAIL spur_run got timeout=%b pair_count=%0d done@%0d last_ret@%0d want done shortly after return, count 1",
                      to, pair_count, done_cyc, ov_last);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      mem_x[k] = $urandom;
      mem_y[k] = $urandom;
      mem_z[k] = $urandom;
    end
    bus.pipe_iready = 1'b1;
    test_reset();
    test_n3();
    test_small_n();
    test_random_ready();
    test_backpressure();
    test_reset_mid_run();
    test_spurious_ovalid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
